// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, instruction
// register handshake to decode, and branch/jump redirect.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        input  imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
        output imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I multicycle fetch stage: PC, single-word imem requests, instruction register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps to ERROR instead of being aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus,
    output logic          fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_HOLD,
        ST_ERROR
    } state_t;

    state_t      state;
    logic [31:0] pc;

    assign bus.imem_addr = pc;

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_RESET;
            pc           <= RESET_PC;
            bus.imem_req <= 1'b0;
            bus.ir_valid <= 1'b0;
            bus.ir_data  <= NOP;
            bus.ir_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault  <= 1'b0;
`endif
        end else if ((state == ST_FETCH || state == ST_HOLD) && bus.redirect_valid) begin
            // Redirect wins over a same-cycle response or accept; the response is dropped.
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state        <= ST_ERROR;
                bus.imem_req <= 1'b0;
                bus.ir_valid <= 1'b0;
                fetch_fault  <= 1'b1;
            end else
`endif
            begin
                state        <= ST_FETCH;
                pc           <= bus.redirect_pc & ~32'h3;
                bus.imem_req <= 1'b1;
                bus.ir_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_RESET: begin
                    state        <= ST_FETCH;
                    bus.imem_req <= 1'b1;
                    bus.ir_valid <= 1'b0;
                end
                ST_FETCH: begin
                    if (bus.imem_rvalid) begin
                        state        <= ST_HOLD;
                        bus.ir_data  <= bus.imem_rdata;
                        bus.ir_pc    <= pc;
                        pc           <= pc + 32'd4;
                        bus.imem_req <= 1'b0;
                        bus.ir_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.ir_ready) begin
                        state        <= ST_FETCH;
                        bus.imem_req <= 1'b1;
                        bus.ir_valid <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    bus.imem_req <= 1'b0;
                    bus.ir_valid <= 1'b0;
                end
                default: begin
                    state        <= ST_RESET;
                    bus.imem_req <= 1'b0;
                    bus.ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multicycle RV32I core; sits directly upstream of the control unit and decode. Holds the program counter, issues single-word requests to instruction memory, and captures each returned word into an instruction register. The instruction is presented to decode through a valid/ready handshake. Supports PC redirect from branch/jump resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state RESET
- imem_req  out  1  instruction memory request; held high until response
- imem_addr  out  32  request address; equals pc, stable while imem_req high
- imem_rvalid  in  1  memory response valid; only meaningful while imem_req high
- imem_rdata  in  32  response word, sampled when imem_rvalid high
- ir_valid  out  1  ir_data/ir_pc hold a fetched instruction
- ir_ready  in  1  decode accepts instruction this cycle
- ir_data  out  32  fetched instruction word
- ir_pc  out  32  address ir_data was fetched from
- redirect_valid  in  1  load new PC (taken branch/jump)
- redirect_pc  in  32  redirect target
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: RESET, FETCH, HOLD, ERROR.
- RESET: imem_req=0, ir_valid=0; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_rvalid: ir_data<=imem_rdata, ir_pc<=pc, pc<=pc+4, -> HOLD.
- HOLD: imem_req=0, ir_valid=1. On ir_ready: -> FETCH. ir_data/ir_pc stable while ir_valid && !ir_ready.
- ERROR: imem_req=0, ir_valid=0, fetch_fault=1; exits only on reset.
- Redirect (any of FETCH/HOLD) takes priority over rvalid and ir_ready in the same cycle: pc<=redirect_pc, -> FETCH, ir_valid low next cycle; a response arriving in the redirect cycle is discarded, IR not updated.
- Redirect in RESET or ERROR state is ignored.
- PC arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Memory contract: no outstanding transactions; memory asserts imem_rvalid only in a cycle with imem_req high; dropping imem_req cancels the request.
- Reset values: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_data=32'h0000_0013 (NOP), ir_pc=RESET_PC, fetch_fault=0, pc=RESET_PC.

## Timing
- Reset deassert: imem_req high at cycle 1 after first non-reset edge (RESET state occupies one cycle).
- Memory latency 0..N cycles: combinational memory may assert imem_rvalid in first FETCH cycle.
- Fetch-to-valid: ir_valid high the cycle after imem_rvalid sampled.
- Handoff: ir_ready in HOLD -> imem_req high next cycle; minimum 2 cycles per instruction with zero-latency memory.
- Redirect: imem_addr=redirect_pc the cycle after redirect_valid.
- Reset mid-operation (any state): all outputs return to reset values next edge; pending response discarded.
- All outputs are registered or decoded from state/pc registers only; no combinational path from inputs to outputs.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=2'b00 -> ERROR, fetch_fault=1 next cycle, pc unchanged.
- Undefined: redirect_pc[1:0] forced to 2'b00 before load; ERROR unreachable; fetch_fault tied 0.

## Test plan
- Reset, memory returns 32'h0050_0093 at 0 latency, ir_ready=1 -> ir_valid at cycle 2, ir_pc=0, next imem_addr=4.
- Memory latency 3, ir_ready=0 for 5 cycles in HOLD -> imem_req low, ir_data/ir_pc stable, ir_valid held; pc=4 after accept.
- Redirect to 32'h0000_0100 same cycle as imem_rvalid -> response dropped, imem_addr=32'h100 next cycle, no ir_valid.
- PC at 32'hFFFF_FFFC fetch accepted -> next imem_addr=32'h0000_0000.
- Redirect to 32'h0000_0102: with FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, imem_req=0 until reset; without -> imem_addr=32'h0000_0100, fetch_fault=0.
- Reset asserted in FETCH with rvalid high -> ir_valid=0, ir_data=32'h0000_0013, imem_addr=RESET_PC next cycle.
